c7bicu_fetch_resp: RTL
======================

C7BICU_FETCH_RESP -- requirements
Module: c7bicu_fetch_resp

Interface
REQ-001 Parameters: none; address width fixed 32, line 4 words x 32 bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 ifu_icu_req_ic1  input  1  fetch request level; held by IFU until the cycle after ack.
REQ-005 ifu_icu_addr_ic1  input  32  fetch address, valid while req=1.
REQ-006 icu_ifu_ack_ic1  output  1  one-cycle request-accept pulse.
REQ-007 icu_ifu_data_valid_ic2  output  1  one-cycle instruction-return pulse.
REQ-008 icu_ifu_data_ic2  output  32  instruction word, valid when data_valid=1.
REQ-009 icu_inv  input  1  invalidate line buffer (level, sampled each cycle).
REQ-010 icu_biu_req  output  1  line-fill request level, held until biu_icu_ack.
REQ-011 icu_biu_addr  output  32  fill address, line-aligned ({addr[31:4],4'b0}).
REQ-012 biu_icu_ack  input  1  fill request accepted.
REQ-013 biu_icu_rvalid  input  1  fill data beat valid.
REQ-014 biu_icu_rdata  input  32  fill data beat, ascending word order 0..3.

Function
REQ-015 The block SHALL contain one line buffer: valid bit, tag addr[31:4], 4 data words.
REQ-016 FSM states SHALL be IDLE, CHK, MREQ, MDATA, RESP.
REQ-017 IDLE with req=1: capture addr, register ack=1 for the next cycle, go CHK.
REQ-018 Ack SHALL be asserted exactly one cycle per accepted request; req sampled outside IDLE is ignored, never acked.
REQ-019 CHK (ack cycle): hit = valid & tag==addr[31:4]; hit -> register data_valid=1 and data=word[addr[3:2]], go IDLE; miss -> go MREQ.
REQ-020 Hit latency: request sampled at edge T -> ack in cycle T+1, data_valid in cycle T+2.
REQ-021 MREQ: icu_biu_req=1, addr line-aligned; on biu_icu_ack go MDATA, clear 2-bit beat counter.
REQ-022 MDATA: each rvalid writes rdata to word[cnt], cnt increments mod 4; rvalid with cnt==3 SHALL set tag, set valid (unless invalidated per REQ-026), go RESP.
REQ-023 RESP: register data_valid=1 with the requested word[addr[3:2]], go IDLE.
REQ-024 Miss latency: data_valid SHALL follow the cycle of the 4th rvalid by exactly 2 cycles.
REQ-025 rvalid outside MDATA and biu_icu_ack outside MREQ SHALL be ignored.
REQ-026 icu_inv SHALL clear valid next edge; icu_inv asserted any cycle during MREQ/MDATA, including the 4th-beat cycle, SHALL leave valid=0 after fill; the current request still receives its fill data.
REQ-027 Every acked request SHALL receive exactly one data_valid; no cancel path exists (IFU flush does not suppress return).
REQ-028 addr[1:0] SHALL be ignored.
REQ-029 data_valid and ack SHALL never be asserted in the same cycle.
REQ-030 icu_ifu_data_ic2 SHALL hold its last value when data_valid=0.

Reset
REQ-031 resetn=0 at an edge SHALL force: state IDLE, valid=0, cnt=0, ack=0, data_valid=0, icu_biu_req=0, data=0.
REQ-032 Reset mid-fill SHALL abandon the fill; subsequent beats ignored; no data_valid for the aborted request.
REQ-033 First request after reset SHALL miss.

Verification
REQ-034 Cold miss: req addr 0x1C000000, biu ack 1 cycle later, beats 0x11,0x22,0x33,0x44 -> biu_addr 0x1C000000, data_valid once with 0x11, 2 cycles after last beat.
REQ-035 Hit: after REQ-034, req 0x1C000008 -> ack T+1, data_valid T+2 with 0x33, no biu_req.
REQ-036 Tag miss: req 0x1C000014 -> new fill at 0x1C000010, old line replaced; then req 0x1C000000 misses.
REQ-037 Invalidate during fill: icu_inv pulsed on 3rd beat of a fill for 0x1C000004 -> data_valid with word1, then re-request 0x1C000004 misses.
REQ-038 Reset during MDATA after 2 beats -> all outputs 0 next cycle, remaining beats ignored, next req misses.
REQ-039 Back-to-back IFU traffic with randomized biu ack/rvalid gaps -> ack count == data_valid count, no ack while busy, ack/data_valid never coincident.

Source files
------------

// File: rtl/c7bicu_fetch_resp_if.sv
// Bundle of the IFU fetch handshake and the BIU line-fill channel seen by the
// fetch responder. slave = the responder, master = the IFU/BIU side.
interface c7bicu_fetch_resp_if;
  logic        ifu_icu_req_ic1;
  logic [31:0] ifu_icu_addr_ic1;
  logic        icu_ifu_ack_ic1;
  logic        icu_ifu_data_valid_ic2;
  logic [31:0] icu_ifu_data_ic2;
  logic        icu_inv;
  logic        icu_biu_req;
  logic [31:0] icu_biu_addr;
  logic        biu_icu_ack;
  logic        biu_icu_rvalid;
  logic [31:0] biu_icu_rdata;

  modport slave (
    input  ifu_icu_req_ic1, ifu_icu_addr_ic1, icu_inv,
           biu_icu_ack, biu_icu_rvalid, biu_icu_rdata,
    output icu_ifu_ack_ic1, icu_ifu_data_valid_ic2, icu_ifu_data_ic2,
           icu_biu_req, icu_biu_addr
  );

  modport master (
    output ifu_icu_req_ic1, ifu_icu_addr_ic1, icu_inv,
           biu_icu_ack, biu_icu_rvalid, biu_icu_rdata,
    input  icu_ifu_ack_ic1, icu_ifu_data_valid_ic2, icu_ifu_data_ic2,
           icu_biu_req, icu_biu_addr
  );
endinterface

// File: rtl/c7bicu_fetch_resp.sv
// Instruction-fetch responder with a single 4-word line buffer; a miss fills
// the line from the BIU and then returns the requested word.
module c7bicu_fetch_resp (
  input  logic               clk,
  input  logic               resetn,
  c7bicu_fetch_resp_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CHK, MREQ, MDATA, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:2] addr_q;
  logic [31:4] tag_q;
  logic        valid_q;
  logic        inv_seen_q;
  logic [1:0]  cnt_q;
  logic [31:0] line_q [4];
  logic        ack_q, data_valid_q;
  logic [31:0] data_q;
  logic        hit, fill_done;
  logic        ack_nxt, data_valid_nxt;
  logic        unused_addr_lsb;

  assign hit             = valid_q && (tag_q == addr_q[31:4]);
  assign fill_done       = (state == MDATA) && bus.biu_icu_rvalid && (cnt_q == 2'd3);
  assign unused_addr_lsb = ^bus.ifu_icu_addr_ic1[1:0];

  assign bus.icu_ifu_ack_ic1        = ack_q;
  assign bus.icu_ifu_data_valid_ic2 = data_valid_q;
  assign bus.icu_ifu_data_ic2       = data_q;
  assign bus.icu_biu_req            = (state == MREQ);
  assign bus.icu_biu_addr           = {addr_q[31:4], 4'b0000};

  // NOTE: state holds with <= so every flop samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no latch forms.
  always_comb begin
    state_nxt      = state;
    ack_nxt        = 1'b0;
    data_valid_nxt = 1'b0;
    unique case (state)
      IDLE:  if (bus.ifu_icu_req_ic1) begin
               ack_nxt   = 1'b1;
               state_nxt = CHK;
             end
      CHK:   if (hit) begin
               data_valid_nxt = 1'b1;
               state_nxt      = IDLE;
             end else begin
               state_nxt = MREQ;
             end
      MREQ:  if (bus.biu_icu_ack) state_nxt = MDATA;
      MDATA: if (fill_done)       state_nxt = RESP;
      RESP:  begin
               data_valid_nxt = 1'b1;
               state_nxt      = IDLE;
             end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q       <= '0;
      tag_q        <= '0;
      valid_q      <= 1'b0;
      inv_seen_q   <= 1'b0;
      cnt_q        <= '0;
      ack_q        <= 1'b0;
      data_valid_q <= 1'b0;
      data_q       <= '0;
    end else begin
      ack_q        <= ack_nxt;
      data_valid_q <= data_valid_nxt;
      if (data_valid_nxt) data_q <= line_q[addr_q[3:2]];
      if (state == IDLE && bus.ifu_icu_req_ic1) addr_q <= bus.ifu_icu_addr_ic1[31:2];

      if (state == MREQ && bus.biu_icu_ack)         cnt_q <= '0;
      else if (state == MDATA && bus.biu_icu_rvalid) cnt_q <= cnt_q + 2'd1;

      // An invalidate seen anywhere in the fill keeps the new line unusable.
      if (state == CHK) inv_seen_q <= 1'b0;
      else if ((state == MREQ || state == MDATA) && bus.icu_inv) inv_seen_q <= 1'b1;

      if (fill_done) begin
        tag_q   <= addr_q[31:4];
        valid_q <= !(inv_seen_q || bus.icu_inv);
      end else if (bus.icu_inv) begin
        valid_q <= 1'b0;
      end
    end
  end

  // NOTE: line storage is not reset; valid_q alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (resetn && state == MDATA && bus.biu_icu_rvalid) line_q[cnt_q] <= bus.biu_icu_rdata;
  end
endmodule
